// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the multi-cycle CPU control path:
//   - opcode constants of the instruction set (OP_ADD .. OP_HALT)
//   - ALU operation encodings (ALU_ADD, ALU_SUB)
//   - sequencer state encoding (3 bits)
//   - ctrl_t, the datapath control word produced by ctrl_decode
//   - op_is_legal(), the single definition of which opcodes exist
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_LW   = 4'h2;
    localparam logic [3:0] OP_SW   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_BEQ  = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_e;

    typedef struct packed {
        logic       mem_enable;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic       jump;
        logic [3:0] alu_op;
        logic       alu_src;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_reg;
    } ctrl_t;

    // Opcodes 7..E are undefined; everything else, including HALT, is legal.
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_JMP) || (op == OP_HALT);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ---------------------------------------------------------------------------
// ctrl_decode
// Purely combinational map from sequencer state to the datapath control word.
// Ports:
//   state_i      current sequencer state (registered in the top level)
//   opcode_i     latched opcode (opcode_q), valid from EXEC onwards
//   zero_i       ALU zero flag, qualifies the PC write of BEQ
//   mem_ready_i  memory handshake, qualifies IR/PC write in FETCH
//   ctrl_o       control word driven to the datapath
// ---------------------------------------------------------------------------
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  state_e     state_i,
    input  logic [3:0] opcode_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output ctrl_t      ctrl_o
);

    logic is_rtype;
    assign is_rtype = (opcode_i == OP_ADD) || (opcode_i == OP_SUB);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            FETCH: begin
                ctrl_o.mem_enable = 1'b1;
                ctrl_o.mem_read   = 1'b1;
                // IR load and PC+1 happen in the cycle the read completes.
                ctrl_o.ir_write   = mem_ready_i;
                ctrl_o.pc_write   = mem_ready_i;
            end
            EXEC: begin
                case (opcode_i)
                    OP_ADD, OP_SUB: begin
                        ctrl_o.alu_op = {3'b000, opcode_i[0]};
                    end
                    OP_ADDI, OP_LW, OP_SW: begin
                        ctrl_o.alu_op  = ALU_ADD;
                        ctrl_o.alu_src = 1'b1;
                    end
                    OP_BEQ: begin
                        ctrl_o.alu_op   = ALU_SUB;
                        ctrl_o.branch   = 1'b1;
                        ctrl_o.pc_write = zero_i;
                    end
                    OP_JMP: begin
                        ctrl_o.jump     = 1'b1;
                        ctrl_o.pc_write = 1'b1;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                // Address computation stays on the ALU for the whole access.
                ctrl_o.alu_op     = ALU_ADD;
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.mem_enable = 1'b1;
                ctrl_o.mem_read   = (opcode_i == OP_LW);
                ctrl_o.mem_write  = (opcode_i == OP_SW);
            end
            WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.mem_reg   = (opcode_i == OP_LW);
                ctrl_o.reg_dst   = is_rtype;
                // ALU result is held stable while it is written back.
                ctrl_o.alu_op    = is_rtype ? {3'b000, opcode_i[0]} : ALU_ADD;
                ctrl_o.alu_src   = (opcode_i == OP_ADDI) || (opcode_i == OP_LW);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Multi-cycle instruction sequencer (FETCH/DECODE/EXEC/MEM/WB) for a CPU
// with a single memory port. Holds state, latched opcode, memory watchdog,
// sticky error and retired-instruction counter; the control word itself is
// decoded from registered state by ctrl_decode.
// Handshake: a memory access is open whenever mem_enable=1; it completes in
// the cycle mem_ready=1 is seen. mem_ready is ignored outside FETCH/MEM.
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   start               one-cycle pulse, leaves IDLE
//   opcode, zero        IR opcode field (sampled in DECODE), ALU zero flag
//   mem_ready           memory completes current access this cycle
//   mem_enable..mem_reg datapath control word
//   busy, halted        status: running / stopped in HALT
//   mem_err             sticky watchdog error
//   illegal_op          one-cycle pulse in DECODE of an undefined opcode
//   retired             retired-instruction count, wraps
// ---------------------------------------------------------------------------
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int RET_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_enable,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic             branch,
    output logic             jump,
    output logic [3:0]       ALU_op,
    output logic             ALU_src,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             mem_reg,
    output logic             busy,
    output logic             halted,
    output logic             mem_err,
    output logic             illegal_op,
    output logic [RET_W-1:0] retired
);

    localparam int WC_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    state_e           state_q;
    logic [3:0]       opcode_q;
    logic [WC_W-1:0]  wait_cnt_q;
    logic [RET_W-1:0] retired_q;
    logic             mem_err_q;
    ctrl_t            ctrl;

    // Last permitted wait cycle without completion; MEM_TIMEOUT=0 disables.
    logic timeout;
    assign timeout = (MEM_TIMEOUT != 0) && !mem_ready && (wait_cnt_q == WC_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            opcode_q   <= '0;
            wait_cnt_q <= '0;
            retired_q  <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= FETCH;
                        wait_cnt_q <= '0;
                    end
                end
                FETCH: begin
                    if (mem_ready) begin
                        state_q <= DECODE;
                    end else if (timeout) begin
                        mem_err_q <= 1'b1;
                        state_q   <= HALT;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WC_W'(1);
                    end
                end
                DECODE: begin
                    opcode_q <= opcode;
                    if (opcode == OP_HALT) begin
                        state_q <= HALT;
                    end else if (!op_is_legal(opcode)) begin
                        // Undefined opcode behaves as a NOP that is not retired.
                        state_q    <= FETCH;
                        wait_cnt_q <= '0;
                    end else begin
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    case (opcode_q)
                        OP_LW, OP_SW: begin
                            state_q    <= MEM;
                            wait_cnt_q <= '0;
                        end
                        OP_BEQ, OP_JMP: begin
                            state_q    <= FETCH;
                            wait_cnt_q <= '0;
                            retired_q  <= retired_q + RET_W'(1);
                        end
                        default: state_q <= WB;
                    endcase
                end
                MEM: begin
                    if (mem_ready) begin
                        if (opcode_q == OP_LW) begin
                            state_q <= WB;
                        end else begin
                            state_q    <= FETCH;
                            wait_cnt_q <= '0;
                            retired_q  <= retired_q + RET_W'(1);
                        end
                    end else if (timeout) begin
                        mem_err_q <= 1'b1;
                        state_q   <= HALT;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WC_W'(1);
                    end
                end
                WB: begin
                    state_q    <= FETCH;
                    wait_cnt_q <= '0;
                    retired_q  <= retired_q + RET_W'(1);
                end
                HALT: state_q <= HALT;
                default: state_q <= IDLE;
            endcase
        end
    end

    ctrl_decode u_decode (
        .state_i     (state_q),
        .opcode_i    (opcode_q),
        .zero_i      (zero),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl)
    );

    assign mem_enable = ctrl.mem_enable;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign ir_write   = ctrl.ir_write;
    assign pc_write   = ctrl.pc_write;
    assign branch     = ctrl.branch;
    assign jump       = ctrl.jump;
    assign ALU_op     = ctrl.alu_op;
    assign ALU_src    = ctrl.alu_src;
    assign reg_dst    = ctrl.reg_dst;
    assign reg_write  = ctrl.reg_write;
    assign mem_reg    = ctrl.mem_reg;

    assign busy    = (state_q != IDLE) && (state_q != HALT);
    assign halted  = (state_q == HALT);
    assign mem_err = mem_err_q;
    assign retired = retired_q;

    // opcode_q is only loaded at the end of DECODE, so the illegal pulse has
    // to look at the live IR opcode field to appear during DECODE itself.
    assign illegal_op = (state_q == DECODE) && !op_is_legal(opcode);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed bench for multicycle_ctrl: reset values, per-state control words
// for ADD and a wait-stated LW, a per-opcode table (latency, controls seen,
// retired count), illegal/HALT handling, FETCH watchdog expiry and the
// last-cycle rescue, and asynchronous reset in the middle of an SW access.
// Inputs change 1 time unit after the rising edge; outputs are sampled 2
// time units after the edge.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;
    import cpu_ctrl_pkg::*;

    localparam int RET_W = 16;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [3:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             mem_enable, mem_read, mem_write, ir_write, pc_write;
    logic             branch, jump, ALU_src, reg_dst, reg_write, mem_reg;
    logic [3:0]       ALU_op;
    logic             busy, halted, mem_err, illegal_op;
    logic [RET_W-1:0] retired;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(16), .RET_W(RET_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_enable (mem_enable),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .branch     (branch),
        .jump       (jump),
        .ALU_op     (ALU_op),
        .ALU_src    (ALU_src),
        .reg_dst    (reg_dst),
        .reg_write  (reg_write),
        .mem_reg    (mem_reg),
        .busy       (busy),
        .halted     (halted),
        .mem_err    (mem_err),
        .illegal_op (illegal_op),
        .retired    (retired)
    );

    // ---------------- scoreboard state ----------------
    int               n_checks = 0;
    int               n_fail   = 0;
    int               n;
    logic [RET_W-1:0] exp_ret;
    logic [15:0]      exp_q[$];   // {latency[5:0], controls_seen[9:0]}

    // Per-opcode table, mem_ready=1 throughout. Controls-seen bit order:
    // {illegal_op, branch, jump, pc_write, reg_write, reg_dst, mem_reg,
    //  mem_write, ALU_src, ALU_op[0]}, OR-ed over all cycles after FETCH.
    logic [3:0] t_op   [9] = '{OP_SUB, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BEQ,
                               OP_JMP, 4'h7, 4'hE};
    logic       t_zero [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [5:0] t_lat  [9] = '{6'd4, 6'd4, 6'd5, 6'd4, 6'd3, 6'd3, 6'd3, 6'd2, 6'd2};
    logic [9:0] t_seen [9] = '{10'b0000110001,   // SUB
                               10'b0000100010,   // ADDI
                               10'b0000101010,   // LW
                               10'b0000000110,   // SW
                               10'b0101000001,   // BEQ taken
                               10'b0100000001,   // BEQ not taken
                               10'b0011000000,   // JMP
                               10'b1000000000,   // illegal 7
                               10'b1000000000};  // illegal E

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] snap();
        return {illegal_op, branch, jump, pc_write, reg_write, reg_dst,
                mem_reg, mem_write, ALU_src, ALU_op[0]};
    endfunction

    // Starts in FETCH with mem_ready=1; runs until the next FETCH (ir_write).
    task automatic run_instr(input string tag, input logic [3:0] op, input logic z);
        logic [9:0]  seen;
        logic [15:0] e;
        int          cnt;
        opcode    = op;
        zero      = z;
        mem_ready = 1'b1;
        seen      = '0;
        cnt       = 0;
        do begin
            cyc;
            #1;
            cnt++;
            if (!ir_write) seen |= snap();
        end while (!ir_write && cnt < 20);
        e = exp_q.pop_front();
        check({tag, " latency"}, cnt, {26'd0, e[15:10]});
        check({tag, " controls"}, {22'd0, seen}, {22'd0, e[9:0]});
        check({tag, " retired"}, retired, exp_ret);
    endtask

    // ---------------- global time limit ----------------
    initial begin
        #200000;
        $display("FAIL time limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; start = 1'b0; opcode = OP_ADD; zero = 1'b0; mem_ready = 1'b0;
        exp_ret = '0;
        cyc; cyc; #1;
        check("reset controls",
              {mem_enable, mem_read, mem_write, ir_write, pc_write, branch, jump,
               ALU_op, ALU_src, reg_dst, reg_write, mem_reg, busy, halted,
               mem_err, illegal_op}, 0);
        check("reset retired", retired, 0);

        // ADD, zero-wait, state by state
        rst = 1'b0; start = 1'b1; mem_ready = 1'b1;
        cyc; start = 1'b0; #1;                       // FETCH
        check("add fetch mem", {mem_enable, mem_read, mem_write}, 3'b110);
        check("add fetch ir/pc/busy", {ir_write, pc_write, busy}, 3'b111);
        cyc; #1;                                     // DECODE
        check("add decode", {mem_enable, ir_write, pc_write, illegal_op, busy}, 5'b00001);
        cyc; #1;                                     // EXEC
        check("add exec", {ALU_op, ALU_src, reg_write}, 6'b000000);
        cyc; #1;                                     // WB
        check("add wb", {reg_write, reg_dst, mem_reg, ALU_op}, 7'b1100000);
        check("add wb retired", retired, 0);
        cyc; #1;                                     // FETCH
        exp_ret = 1;
        check("add retired", retired, exp_ret);
        check("add back in fetch", {ir_write, mem_read}, 2'b11);

        // LW with three wait cycles in MEM
        opcode = OP_LW; n = 0;
        cyc; #1; n++;                                // DECODE
        cyc; #1; n++;                                // EXEC
        check("lw exec", {ALU_op, ALU_src}, 5'b00001);
        mem_ready = 1'b0;
        cyc; n++;                                    // MEM cycle 1
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            #1;
            check($sformatf("lw mem cycle %0d", i),
                  {mem_enable, mem_read, mem_write, ALU_src}, 4'b1101);
            cyc; n++;
        end
        #1;                                          // WB
        check("lw wb", {reg_write, mem_reg, reg_dst, ALU_src}, 4'b1101);
        check("lw wb retired", retired, exp_ret);
        cyc; #1; n++;                                // FETCH
        exp_ret = exp_ret + 1'b1;
        check("lw latency", n, 8);
        check("lw retired", retired, exp_ret);

        // Opcode table
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back({t_lat[i], t_seen[i]});
            if (i < 7) exp_ret = exp_ret + 1'b1;
            run_instr($sformatf("op%0h z%0d", t_op[i], t_zero[i]), t_op[i], t_zero[i]);
        end

        // HALT, start ignored afterwards
        opcode = OP_HALT;
        cyc; #1;                                     // DECODE
        check("halt decode no illegal", illegal_op, 0);
        cyc; #1;                                     // HALT
        check("halt state", {halted, busy, mem_enable, mem_read, mem_err}, 5'b10000);
        start = 1'b1; cyc; start = 1'b0; cyc; #1;
        check("halt ignores start", {halted, busy, mem_enable}, 3'b100);
        check("halt retired", retired, exp_ret);

        // Watchdog expiry in FETCH
        rst = 1'b1; #1;
        check("async reset from halt", {halted, mem_err, busy}, 3'b000);
        check("async reset retired", retired, 0);
        cyc; rst = 1'b0; mem_ready = 1'b0; start = 1'b1;
        cyc; start = 1'b0; #1;                       // FETCH wait cycle 1
        for (int i = 0; i < 15; i++) cyc;
        #1;                                          // FETCH wait cycle 16
        check("timeout last wait", {mem_enable, halted, mem_err}, 3'b100);
        cyc; #1;
        check("timeout halt", {mem_enable, halted, mem_err, busy}, 4'b0110);
        start = 1'b1; cyc; start = 1'b0; cyc; #1;
        check("mem_err sticky", {halted, mem_err}, 2'b11);

        // mem_ready on the 16th wait cycle rescues the fetch
        rst = 1'b1; cyc; rst = 1'b0; mem_ready = 1'b0; start = 1'b1;
        cyc; start = 1'b0;                           // FETCH wait cycle 1
        for (int i = 0; i < 15; i++) cyc;            // FETCH wait cycle 16
        mem_ready = 1'b1; opcode = OP_ADD; #1;
        check("ready on last wait", {ir_write, mem_err}, 2'b10);
        cyc; #1;                                     // DECODE
        check("no timeout", {halted, mem_err, busy}, 3'b001);
        cyc; cyc; cyc; #1;                           // EXEC, WB, FETCH
        check("rescued add retired", retired, 1);

        // Asynchronous reset in the middle of an SW access
        opcode = OP_SW;
        cyc;                                         // DECODE
        cyc;                                         // EXEC
        mem_ready = 1'b0;
        cyc; #1;                                     // MEM
        check("sw mem", {mem_enable, mem_write, mem_read}, 3'b110);
        #2; rst = 1'b1; #1;
        check("rst mid mem", {mem_enable, mem_write, busy, halted, mem_err}, 5'b00000);
        check("rst mid mem retired", retired, 0);
        cyc; rst = 1'b0; cyc; #1;
        check("idle after reset", {busy, mem_enable}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
